// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Receives a length-prefixed byte stream, packs little-endian 32-bit words,
// writes them to instruction memory from address 0 and releases the core
// once the trailing checksum matches.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned LEN_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        reload,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_hold,
  output logic        done,
  output logic        err_len,
  output logic        err_csum
);

  typedef enum logic [2:0] {StLen0, StLen1, StData, StCsum, StDone} state_e;

  state_e state_q, state_d;

  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [7:0]       sum_q, sum_d;
  logic [31:0]      word_q, word_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             err_len_q, err_len_d;
  logic             err_csum_q, err_csum_d;

  logic             accept;
  logic [LEN_W-1:0] hdr_len;
  logic             last_byte;
  logic [31:0]      merged;
  logic [31:0]      word_addr;

  assign accept    = in_valid && in_ready;
  // Full header length as it stands once the high byte arrives.
  assign hdr_len   = LEN_W'({in_data, len_q[7:0]});
  assign last_byte = (count_q + LEN_W'(1)) == len_q;
  assign word_addr = 32'(count_q) & ~32'd3;

  // Current word buffer with the incoming byte dropped into its lane.
  always_comb begin
    merged = word_q;
    merged[{count_q[1:0], 3'b000} +: 8] = in_data;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLen0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLen0:  if (accept) state_d = StLen1;
      StLen1:  if (accept) state_d = (hdr_len == '0) ? StCsum : StData;
      StData:  if (accept && last_byte) state_d = StCsum;
      StCsum:  if (accept) state_d = StDone;
      StDone:  if (reload) state_d = StLen0;
      default: state_d = StLen0;
    endcase
  end

  // FSM outputs and registered status.
  always_comb begin
    in_ready  = (state_q != StDone);
    wr_en     = wr_en_q;
    wr_addr   = wr_addr_q;
    wr_data   = wr_data_q;
    core_hold = hold_q;
    done      = done_q;
    err_len   = err_len_q;
    err_csum  = err_csum_q;
  end

  // Datapath next-state: header capture, word packing, checksum, status.
  always_comb begin
    len_d      = len_q;
    count_d    = count_q;
    sum_d      = sum_q;
    word_d     = word_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_len_d  = err_len_q;
    err_csum_d = err_csum_q;
    unique case (state_q)
      StLen0: begin
        if (accept) len_d = LEN_W'(in_data);
      end
      StLen1: begin
        if (accept) begin
          len_d     = hdr_len;
          err_len_d = 32'(hdr_len) > MEM_BYTES;
        end
      end
      StData: begin
        if (accept) begin
          sum_d   = sum_q + in_data;
          count_d = count_q + LEN_W'(1);
          if (count_q[1:0] == 2'd3 || last_byte) begin
            // Clear the buffer so a short final word has zero upper lanes.
            word_d = '0;
            if (!err_len_q) begin
              wr_en_d   = 1'b1;
              wr_addr_d = word_addr;
              wr_data_d = merged;
            end
          end else begin
            word_d = merged;
          end
        end
      end
      StCsum: begin
        if (accept) begin
          err_csum_d = (in_data != sum_q);
          done_d     = 1'b1;
          hold_d     = err_len_q || (in_data != sum_q);
        end
      end
      StDone: begin
        if (reload) begin
          hold_d     = 1'b1;
          done_d     = 1'b0;
          err_len_d  = 1'b0;
          err_csum_d = 1'b0;
          count_d    = '0;
          sum_d      = '0;
          word_d     = '0;
          len_d      = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= '0;
      count_q    <= '0;
      sum_q      <= '0;
      word_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_len_q  <= 1'b0;
      err_csum_q <= 1'b0;
    end else begin
      len_q      <= len_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      word_q     <= word_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_len_q  <= err_len_d;
      err_csum_q <= err_csum_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed streams, expected writes
// queued at issue time and checked by an independent write monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        reload = 1'b0;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_hold;
  logic        done;
  logic        err_len;
  logic        err_csum;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];
  logic        prev_wr_en = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  logic [7:0] prog [10] = '{8'h08, 8'h00, 8'h03, 8'h21, 8'h40,
                            8'h01, 8'h93, 8'h01, 8'h10, 8'h01};
  logic [7:0] part [8]  = '{8'h05, 8'h00, 8'h13, 8'h00, 8'h00,
                            8'h00, 8'hAA, 8'hBD};

  imem_loader #(
    .MEM_BYTES(128),
    .LEN_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .reload(reload),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .core_hold(core_hold),
    .done(done),
    .err_len(err_len),
    .err_csum(err_csum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    logic [63:0] e;
    if (wr_en === 1'b1) begin
      check("single_strobe", {31'd0, prev_wr_en && (prev_addr == wr_addr)}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write",
                 wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[63:32]);
        check("wr_data", wr_data, e[31:0]);
      end
    end
    prev_wr_en = (wr_en === 1'b1);
    prev_addr  = wr_addr;
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready low for %0d cycles, required accept", n);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_prog(input logic [7:0] csum);
    for (int i = 0; i < 10; i++) send_byte(prog[i], 1'b0);
    send_byte(csum, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic push_prog_writes();
    exp_q.push_back({32'h0000_0000, 32'h0140_2103});
    exp_q.push_back({32'h0000_0004, 32'h0110_0193});
  endtask

  task automatic check_done(input logic e_len, input logic e_csum, input logic e_hold);
    repeat (2) @(posedge clk);
    #1;
    check("done", {31'd0, done}, 32'd1);
    check("err_len", {31'd0, err_len}, {31'd0, e_len});
    check("err_csum", {31'd0, err_csum}, {31'd0, e_csum});
    check("core_hold", {31'd0, core_hold}, {31'd0, e_hold});
    check("in_ready_done", {31'd0, in_ready}, 32'd0);
    check("writes_pending", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_core_hold", {31'd0, core_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err_len", {31'd0, err_len}, 32'd0);
    check("rst_err_csum", {31'd0, err_csum}, 32'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;

    // Two-word program, continuous valid.
    push_prog_writes();
    send_prog(8'h0A);
    check_done(1'b0, 1'b0, 1'b0);

    // Partial final word with alternating-cycle valid.
    do_reset();
    exp_q.push_back({32'h0000_0000, 32'h0000_0013});
    exp_q.push_back({32'h0000_0004, 32'h0000_00AA});
    for (int i = 0; i < 8; i++) send_byte(part[i], 1'b1);
    in_valid = 1'b0;
    check_done(1'b0, 1'b0, 1'b0);

    // Bad checksum: writes still happen, core stays held.
    do_reset();
    push_prog_writes();
    send_prog(8'h0B);
    check_done(1'b0, 1'b1, 1'b1);

    // Oversize length 132: payload 0..131 sums to 0xC6, no writes allowed.
    do_reset();
    send_byte(8'h84, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 132; i++) send_byte(8'(i), 1'b0);
    send_byte(8'hC6, 1'b0);
    in_valid = 1'b0;
    check_done(1'b1, 1'b0, 1'b1);

    // Zero length, then reload and a full program.
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    in_valid = 1'b0;
    check_done(1'b0, 1'b0, 1'b0);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check("reload_hold", {31'd0, core_hold}, 32'd1);
    check("reload_done", {31'd0, done}, 32'd0);
    check("reload_ready", {31'd0, in_ready}, 32'd1);
    push_prog_writes();
    send_prog(8'h0A);
    check_done(1'b0, 1'b0, 1'b0);

    // Reset right after the 6th byte: addr-0 write lands, addr-4 never does.
    do_reset();
    exp_q.push_back({32'h0000_0000, 32'h0140_2103});
    for (int i = 0; i < 6; i++) send_byte(prog[i], 1'b0);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_reset_pending", exp_q.size(), 32'd0);
    push_prog_writes();
    send_prog(8'h0A);
    check_done(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory, complementing the core's read-only fetch port.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Writes each word to instruction memory at word-aligned byte addresses starting at 0.
- Holds the core in reset until a program has loaded with a clean checksum.
- Sits between the host byte link (UART receiver) and the instruction memory write port.

Parameters:
MEM_BYTES, 128, instruction memory size in bytes; must be a multiple of 4.
LEN_W, 16, width of the length header and byte counter.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader can accept a byte this cycle
reload  input  1  single-cycle pulse; starts a new load from DONE
wr_en  output  1  one-cycle instruction memory write strobe
wr_addr  output  32  word-aligned byte address of the write
wr_data  output  32  little-endian assembled word
core_hold  output  1  holds the core (PC and pipeline) in reset
done  output  1  load sequence finished
err_len  output  1  header length exceeded MEM_BYTES
err_csum  output  1  checksum mismatch

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: state=LEN0, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, core_hold=1, done=0, err_len=0, err_csum=0. The byte counter, checksum accumulator and word buffer all clear to 0.
- Byte acceptance: a byte is accepted only on a cycle with in_valid && in_ready. in_data may change freely when it is not accepted.
- Stream format: LEN lo byte, LEN hi byte, LEN payload bytes, then one checksum byte.
- Checksum rule: the checksum byte equals the 8-bit sum, mod 256, of the payload bytes.
- State LEN0: accept a byte and store it as LEN[7:0], then go to LEN1.
- State LEN1: accept a byte and store it as LEN[15:8]. In the same cycle set err_len = (LEN > MEM_BYTES). If LEN==0, go to CSUM; otherwise go to DATA.
- State DATA, per accepted byte:
  - Place the byte into word lane count[1:0]; lane 0 is bits [7:0].
  - Add the byte to the checksum.
  - Increment count.
- Word write trigger: a write is due when the accepted byte makes count[1:0] wrap to 0, or when it is the last payload byte (count+1==LEN).
  - If err_len==0, the next cycle drives wr_en=1 for exactly one cycle.
  - wr_addr = byte address of lane 0 of that word (0, 4, 8, ...).
  - wr_data = the assembled word. Unfilled upper lanes of a final partial word are 0x00.
  - If err_len==1, no write occurs, but payload bytes are still consumed and summed.
  - After the last payload byte, go to CSUM.
- Word buffer: cleared after each issued word, so stale bytes never leak into the next word.
- Back-to-back writes: the memory accepts one write per cycle, so writes may occur on consecutive cycles.
- State CSUM: accept one byte and set err_csum = (byte != sum). Go to DONE with done=1.
  - core_hold falls to 0 in the cycle done rises, only if err_len==0 && err_csum==0.
  - Otherwise core_hold stays 1.
- State DONE:
  - in_ready=0.
  - done, err_len, err_csum and core_hold are held.
  - On reload=1: go to LEN0, set core_hold=1, clear done, err flags, count, sum and buffer.
  - reload is ignored in every state other than DONE.
- Address range: wr_addr never exceeds MEM_BYTES-4, because LEN ≤ MEM_BYTES is guaranteed whenever writes occur.
- Reset mid-operation: reset in any state returns to the reset values. A pending write strobe is cancelled and any partial word is discarded. Memory contents already written are not cleared.
- Simultaneous reset and an accepted byte: reset wins and the byte is dropped.

Test Plan:
- Two-word program: stream 08 00 03 21 40 01 93 01 10 01 0A, in_valid continuous.
  - Required: wr_en pulses with (addr 0, 0x01402103) and (addr 4, 0x01100193).
  - Then done=1, err_len=0, err_csum=0, core_hold=0, in_ready=0.
- Partial final word with backpressure: stream 05 00 13 00 00 00 AA BD, with in_valid low on alternating cycles.
  - Required writes: (0, 0x00000013) and (4, 0x000000AA), each a single-cycle strobe.
  - done=1 with no errors.
- Bad checksum: the two-word stream with checksum byte 0B.
  - Required: both writes still occur, then done=1, err_csum=1, core_hold stays 1.
- Oversize length: header 84 00 (132 > 128), 132 payload bytes, then the correct checksum.
  - Required: wr_en never asserts, err_len=1, done=1, core_hold=1.
- Zero length and reload: stream 00 00 00.
  - Required: no writes; done=1 and core_hold=0.
  - Then pulse reload and send the two-word program again: core_hold returns to 1 the next cycle, and the full sequence repeats.
- Reset mid-load: assert reset after the 6th byte of the two-word stream.
  - Required: outputs return to reset values, the pending addr-4 write is never issued, and a fresh full stream then loads correctly.
